// File: rtl/mac_pkg.sv
// Shared defaults and the lane accumulate step for the vector MAC engine.
// The accumulate step is used by the RTL lanes and the reference model alike.
package mac_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ACC_WIDTH_DEF  = 3 * DATA_WIDTH_DEF;
    localparam int unsigned NUM_CH_DEF     = 4;
    localparam int unsigned LEN_WIDTH_DEF  = 8;
    localparam int unsigned ACC_MAX        = 64;
    localparam int unsigned ACC_EXT        = ACC_MAX + 1;

    typedef struct packed {
        logic               ovf;
        logic [ACC_MAX-1:0] sum;
    } acc_res_t;

    // Add p to acc within a w-bit accumulator; saturate or wrap on overflow.
    function automatic acc_res_t acc_add(input logic [ACC_MAX-1:0] acc,
                                         input logic [ACC_MAX-1:0] p,
                                         input logic               sat,
                                         input int unsigned        w);
        logic [ACC_EXT-1:0] s;
        logic [ACC_EXT-1:0] lim;
        acc_res_t           r;
        s     = {1'b0, acc} + {1'b0, p};
        lim   = ACC_EXT'(1) << w;
        r.ovf = (s >= lim);
        if (r.ovf && sat) begin
            r.sum = ACC_MAX'(lim - ACC_EXT'(1));
        end else begin
            r.sum = ACC_MAX'(s & (lim - ACC_EXT'(1)));
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_vec_lane.sv
// One MAC lane: product register, accumulator, sticky overflow and result register.
// MAC_VEC_SAT_EN selects saturating accumulation with overflow reporting.
module mac_vec_lane
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  adv,
    input  logic                  first,
    input  logic                  last,
    output logic [ACC_WIDTH-1:0]  c,
    output logic                  ovf
);

    localparam int unsigned P_WIDTH = 2 * DATA_WIDTH;
`ifdef MAC_VEC_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic [P_WIDTH-1:0]   p;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf_run;
    acc_res_t             add_c;
    logic [ACC_WIDTH-1:0] nxt_sum_c;
    logic                 nxt_ovf_c;
    logic                 unused_sum_c;

    // First beat restarts the sum; later beats add with wrap or saturation.
    always_comb begin
        add_c        = acc_add(ACC_MAX'(acc), ACC_MAX'(p), SAT, ACC_WIDTH);
        unused_sum_c = ^add_c.sum[ACC_MAX-1:ACC_WIDTH];
        nxt_sum_c    = add_c.sum[ACC_WIDTH-1:0];
        nxt_ovf_c    = SAT & (ovf_run | add_c.ovf);
        if (first) begin
            nxt_sum_c = ACC_WIDTH'(p);
            nxt_ovf_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p       <= '0;
            acc     <= '0;
            ovf_run <= 1'b0;
            c       <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            p       <= '0;
            acc     <= '0;
            ovf_run <= 1'b0;
            c       <= '0;
            ovf     <= 1'b0;
        end else begin
            if (load) begin
                p <= P_WIDTH'(a) * P_WIDTH'(b);
            end
            if (adv) begin
                acc     <= nxt_sum_c;
                ovf_run <= nxt_ovf_c;
                if (last) begin
                    c   <= nxt_sum_c;
                    ovf <= nxt_ovf_c;
                end
            end
        end
    end

endmodule

// File: rtl/mac_vec_pipe.sv
// Multi-lane pipelined dot-product engine with valid/ready in and out.
// Define MAC_VEC_SAT_EN for saturating accumulation and per-lane overflow flags.
module mac_vec_pipe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = 3 * DATA_WIDTH,
    parameter int unsigned NUM_CH     = NUM_CH_DEF,
    parameter int unsigned LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [LEN_WIDTH-1:0]          len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  a_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  b_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_CH*ACC_WIDTH-1:0]   c_out,
    output logic [NUM_CH-1:0]             ovf,
    output logic                          busy
);

    logic [LEN_WIDTH-1:0] cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 s1_valid;
    logic                 s1_first;
    logic                 s1_last;
    logic                 stall_c;
    logic                 accept_c;
    logic                 adv_c;
    logic                 beat_first_c;
    logic                 beat_last_c;
    logic [LEN_WIDTH-1:0] len_cur_c;

    // Handshake and beat-position decode; a last beat waiting on a full output stalls the pipe.
    always_comb begin
        stall_c      = s1_valid & s1_last & out_valid & ~out_ready;
        in_ready     = ~clr & ~stall_c;
        accept_c     = in_valid & in_ready;
        adv_c        = s1_valid & ~stall_c & ~clr;
        beat_first_c = (cnt == '0);
        len_cur_c    = len_q;
        if (beat_first_c) begin
            len_cur_c = (len == '0) ? LEN_WIDTH'(1) : len;
        end
        beat_last_c  = (cnt == len_cur_c - LEN_WIDTH'(1));
        busy         = (cnt != '0) | s1_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            len_q     <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            cnt       <= '0;
            len_q     <= '0;
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                if (beat_first_c) begin
                    len_q <= len_cur_c;
                end
                cnt <= beat_last_c ? '0 : cnt + LEN_WIDTH'(1);
            end
            if (!stall_c) begin
                s1_valid <= accept_c;
                s1_first <= beat_first_c;
                s1_last  <= beat_last_c;
            end
            if (adv_c && s1_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        mac_vec_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .load  (accept_c),
            .a     (a_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .b     (b_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .adv   (adv_c),
            .first (s1_first),
            .last  (s1_last),
            .c     (c_out[i*ACC_WIDTH +: ACC_WIDTH]),
            .ovf   (ovf[i])
        );
    end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Randomized self-checking bench for mac_vec_pipe against a dot-product reference model.
// Expectations follow MAC_VEC_SAT_EN when it is defined.
module tb_mac_vec_pipe;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 24;
    localparam int unsigned AW16 = 16;
    localparam int unsigned NCH  = 4;
    localparam int unsigned LW   = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clr = 1'b0;
    logic [LW-1:0]       len = '0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [NCH*DW-1:0]   a_in = '0;
    logic [NCH*DW-1:0]   b_in = '0;
    logic                in_ready, out_valid, busy;
    logic [NCH*AW-1:0]   c_out;
    logic [NCH-1:0]      ovf;
    logic                in_ready16, out_valid16, busy16;
    logic [NCH*AW16-1:0] c_out16;
    logic [NCH-1:0]      ovf16;

    mac_vec_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_CH(NCH), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .c_out(c_out), .ovf(ovf), .busy(busy));

    mac_vec_pipe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW16), .NUM_CH(NCH), .LEN_WIDTH(LW)) dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .len(len), .in_valid(in_valid), .in_ready(in_ready16),
        .a_in(a_in), .b_in(b_in), .out_valid(out_valid16), .out_ready(out_ready),
        .c_out(c_out16), .ovf(ovf16), .busy(busy16));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-lane running dot products and a queue of pending results
    longint            m_sum [NCH];
    int                m_cnt = 0;
    int                m_len = 1;
    logic [NCH*AW-1:0] q_c [$];
    logic [NCH-1:0]    q_o [$];
    logic              stab_chk = 1'b0;
    logic [NCH*AW-1:0] prev_c;
    logic [NCH*AW-1:0] last_c;
    int                ir_low = 0;
    int                n_res = 0;

    function automatic void push_result();
        logic [NCH*AW-1:0] c;
        logic [NCH-1:0]    o;
        longint            mx;
        mx = (longint'(1) << AW) - 1;
        for (int i = 0; i < NCH; i++) begin
`ifdef MAC_VEC_SAT_EN
            o[i] = (m_sum[i] > mx);
            c[i*AW +: AW] = AW'(o[i] ? mx : m_sum[i]);
`else
            o[i] = 1'b0;
            c[i*AW +: AW] = AW'(m_sum[i] & mx);
`endif
        end
        q_c.push_back(c);
        q_o.push_back(o);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q_c.delete();
            q_o.delete();
            m_cnt    = 0;
            stab_chk = 1'b0;
        end else begin
            if (in_valid && !in_ready && !clr) ir_low++;
            if (stab_chk) begin
                check("held_c", c_out, prev_c);
                check("held_v", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (q_c.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    check("c_out", c_out, q_c.pop_front());
                    check("ovf", ovf, q_o.pop_front());
                    last_c = c_out;
                    n_res++;
                end
            end
            stab_chk = out_valid && !out_ready;
            prev_c   = c_out;
            if (clr) begin
                q_c.delete();
                q_o.delete();
                m_cnt    = 0;
                stab_chk = 1'b0;
            end else if (in_valid && in_ready) begin
                if (m_cnt == 0) begin
                    m_len = (len == 0) ? 1 : int'(len);
                    for (int i = 0; i < NCH; i++) m_sum[i] = 0;
                end
                for (int i = 0; i < NCH; i++)
                    m_sum[i] += longint'(a_in[i*DW +: DW]) * longint'(b_in[i*DW +: DW]);
                m_cnt++;
                if (m_cnt == m_len) begin
                    push_result();
                    m_cnt = 0;
                end
            end
        end
    end

    function automatic logic [NCH*DW-1:0] rep(input int v);
        logic [NCH*DW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*DW +: DW] = DW'(v);
        return r;
    endfunction

    task automatic send(input logic [LW-1:0] l, input logic [NCH*DW-1:0] a, input logic [NCH*DW-1:0] b);
        int t = 0;
        len = l; a_in = a; b_in = b; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while ((q_c.size() != 0 || busy || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", t < 300, 1);
        @(posedge clk); #1;
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_ov", out_valid, 0);
        check("rst_c", c_out, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_ir", in_ready, 1);
    endtask

    logic done = 1'b0;

    initial begin
        int n0, st, t;
        repeat (2) @(posedge clk);
        #1;
        check("init_ov", out_valid, 0);
        check("init_c", c_out, 0);
        check("init_ovf", ovf, 0);
        check("init_busy", busy, 0);
        rst_n = 1'b1;
        check("init_ir", in_ready, 1);

        // Single 4-beat vector, latency check
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            send(4, {DW'($urandom), DW'($urandom), 8'd255, 8'd3}, {DW'($urandom), DW'($urandom), 8'd255, 8'd5});
        @(negedge clk);
        check("t1_lat_k1", out_valid, 0);
        @(negedge clk);
        check("t1_lat_k2", out_valid, 1);
        check("t1_c0", c_out[AW-1:0], 60);
        check("t1_c1", c_out[2*AW-1:AW], 260100);
        drain();

        // len=1 back-to-back stream
        ir_low = 0;
        n0 = n_res;
        for (int i = 0; i < 8; i++) send(1, rep(i), rep(2));
        drain();
        check("t2_ir", ir_low, 0);
        check("t2_n", n_res - n0, 8);
        check("t2_last", last_c, {NCH{AW'(14)}});

        // Output backpressure with two len=2 vectors
        out_ready = 1'b0;
        n0 = n_res;
        st = cyc;
        for (int k = 0; k < 4; k++) send(2, $urandom, $urandom);
        @(negedge clk);
        check("t3_stall_ir", in_ready, 0);
        check("t3_ov", out_valid, 1);
        check("t3_busy", busy, 1);
        while (cyc < st + 10) @(posedge clk);
        #1;
        drain();
        check("t3_n", n_res - n0, 2);

        // Narrow accumulator overflow behaviour
        out_ready = 1'b1;
        send(2, rep(255), rep(255));
        send(2, rep(255), rep(255));
        t = 0;
        while (!out_valid16 && t < 10) begin
            @(negedge clk);
            t++;
        end
`ifdef MAC_VEC_SAT_EN
        check("t4_c16", c_out16, {NCH{16'hFFFF}});
        check("t4_ovf16", ovf16, {NCH{1'b1}});
`else
        check("t4_c16", c_out16, {NCH{16'd64514}});
        check("t4_ovf16", ovf16, 0);
`endif
        check("t4_ir16", in_ready16 & ~busy16, 1);
        drain();

        // clr aborts a partial vector
        send(4, rep(9), rep(9));
        send(4, rep(9), rep(9));
        n0 = n_res;
        clr = 1'b1; in_valid = 1'b1; len = 2; a_in = rep(50); b_in = rep(50);
        @(negedge clk);
        check("t5_clr_ir", in_ready, 0);
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_ov", out_valid, 0);
        send(2, rep(1), rep(1));
        send(2, rep(1), rep(1));
        drain();
        check("t5_n", n_res - n0, 1);
        check("t5_c", last_c, {NCH{AW'(2)}});

        // Async reset mid-vector and while a result is held
        send(4, $urandom, $urandom);
        send(4, $urandom, $urandom);
        rst_pulse();
        send(2, $urandom, $urandom);
        send(2, $urandom, $urandom);
        drain();
        out_ready = 1'b0;
        send(1, rep(7), rep(3));
        @(negedge clk);
        @(negedge clk);
        check("t6_ov_held", out_valid, 1);
        rst_pulse();
        n0 = n_res;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) send(3, $urandom, $urandom);
        drain();
        check("t6_n", n_res - n0, 1);

        // Random vectors, random gaps, random sink backpressure, len changes mid-vector
        n0 = n_res;
        fork
            begin
                for (int v = 0; v < 40; v++) begin
                    int l, nb;
                    l  = $urandom_range(0, 5);
                    nb = (l == 0) ? 1 : l;
                    for (int k = 0; k < nb; k++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk); #1;
                        end
                        send(LW'((k == 0) ? l : $urandom_range(0, 7)), $urandom, $urandom);
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("rand_n", n_res - n0, 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
